// File: rtl/asi_arb.sv
// Purpose : arbitrates the shared user-side memory port between the AXI slave write path and read path.
// Latency : 1 cycle from a sampled request (at an arbitration point) to the registered grant.
// Backpr. : a grant is held until the owner's done pulse or watchdog expiry; request drop does not release it.
//
// Ports:
//   clk, rst_n                   usr_clk domain, asynchronous active-low reset
//   usr_wrequest / usr_rrequest  pending burst on the write / read path
//   usr_wdone / usr_rdone        single-cycle end-of-burst pulses from the owner
//   usr_wgrant / usr_rgrant      registered, mutually exclusive grants
//   arb_err / err_clr            sticky watchdog-expiry flag and its clear
module asi_arb #(
    parameter int ASI_ARB    = 0,     // 1: read has priority, 0: write has priority
    parameter int MAX_CONSEC = 4,     // consecutive priority grants under contention; 0 = strict
    parameter int TIMEOUT    = 1024,  // grant watchdog in cycles; 0 = disabled
    parameter int CNTW       = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1,
    parameter int CONW       = ($clog2(MAX_CONSEC + 1) > 0) ? $clog2(MAX_CONSEC + 1) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic usr_wrequest,
    input  logic usr_rrequest,
    input  logic usr_wdone,
    input  logic usr_rdone,
    output logic usr_wgrant,
    output logic usr_rgrant,
    output logic arb_err,
    input  logic err_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WGNT = 2'd1,
        RGNT = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] WD_LAST = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CONW-1:0] CON_MAX = CONW'(MAX_CONSEC);
    localparam logic            RD_PRI  = (ASI_ARB != 0);

    state_t          state_q,    state_d;
    logic            wgrant_q,   wgrant_d;
    logic            rgrant_q,   rgrant_d;
    logic            arb_err_q,  arb_err_d;
    logic [CONW-1:0] cons_cnt_q, cons_cnt_d;
    logic [CNTW-1:0] wd_cnt_q,   wd_cnt_d;

    logic owner_done;
    logic wd_exp;
    logic arb_pt;
    logic both_req;
    logic limit_hit;
    logic pick_r;

    always_comb begin
        // Done pulses from the side that does not own the port are ignored.
        owner_done = ((state_q == WGNT) && usr_wdone) || ((state_q == RGNT) && usr_rdone);
        // A done in the same cycle as the last watchdog count takes precedence.
        wd_exp     = (TIMEOUT != 0) && (state_q != IDLE) && (wd_cnt_q == WD_LAST) && !owner_done;
        arb_pt     = (state_q == IDLE) || owner_done || wd_exp;
        both_req   = usr_wrequest && usr_rrequest;
        limit_hit  = (MAX_CONSEC != 0) && (cons_cnt_q == CON_MAX);

        // Under contention the priority side wins unless it has used up its run.
        if (both_req) begin
            pick_r = RD_PRI ? !limit_hit : limit_hit;
        end else begin
            pick_r = usr_rrequest;
        end

        state_d    = state_q;
        cons_cnt_d = cons_cnt_q;
        wd_cnt_d   = wd_cnt_q;

        if (arb_pt) begin
            wd_cnt_d = '0;
            if (usr_wrequest || usr_rrequest) begin
                state_d = pick_r ? RGNT : WGNT;
                if (pick_r != RD_PRI) begin
                    cons_cnt_d = '0;
                end else if (both_req && (cons_cnt_q != CON_MAX)) begin
                    cons_cnt_d = cons_cnt_q + CONW'(1);
                end
            end else begin
                state_d = IDLE;
            end
        end else if (state_q != IDLE) begin
            wd_cnt_d = wd_cnt_q + CNTW'(1);
        end

        if (TIMEOUT == 0) begin
            wd_cnt_d = '0;
        end

        wgrant_d = (state_d == WGNT);
        rgrant_d = (state_d == RGNT);

        // A fresh expiry beats a simultaneous clear.
        if (wd_exp) begin
            arb_err_d = 1'b1;
        end else if (err_clr) begin
            arb_err_d = 1'b0;
        end else begin
            arb_err_d = arb_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wgrant_q   <= 1'b0;
            rgrant_q   <= 1'b0;
            arb_err_q  <= 1'b0;
            cons_cnt_q <= '0;
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            wgrant_q   <= wgrant_d;
            rgrant_q   <= rgrant_d;
            arb_err_q  <= arb_err_d;
            cons_cnt_q <= cons_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

    assign usr_wgrant = wgrant_q;
    assign usr_rgrant = rgrant_q;
    assign arb_err    = arb_err_q;

endmodule

// File: tb/tb_asi_arb.sv
// Purpose : directed self-checking bench for asi_arb (write-priority/limited/watchdog and read-priority/strict/no-watchdog).
// Latency : checks are taken 1 time unit after each rising edge.
// Backpr. : not applicable; all waits are fixed cycle counts.
module tb_asi_arb;

    logic clk = 1'b0;
    logic rst_n;

    // Instance 0: write priority, MAX_CONSEC=4, TIMEOUT=8
    logic w_req, r_req, w_done, r_done, clr0;
    logic wg0, rg0, err0;
    // Instance 1: read priority, strict, watchdog disabled
    logic b_w_req, b_r_req, b_w_done, b_r_done, clr1;
    logic wg1, rg1, err1;

    int n_cmp = 0;
    int n_err = 0;

    bit exp_r [0:9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    asi_arb #(.ASI_ARB(0), .MAX_CONSEC(4), .TIMEOUT(8)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .usr_wrequest(w_req), .usr_rrequest(r_req),
        .usr_wdone(w_done), .usr_rdone(r_done),
        .usr_wgrant(wg0), .usr_rgrant(rg0),
        .arb_err(err0), .err_clr(clr0)
    );

    asi_arb #(.ASI_ARB(1), .MAX_CONSEC(0), .TIMEOUT(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .usr_wrequest(b_w_req), .usr_rrequest(b_r_req),
        .usr_wdone(b_w_done), .usr_rdone(b_r_done),
        .usr_wgrant(wg1), .usr_rgrant(rg1),
        .arb_err(err1), .err_clr(clr1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        w_req = 0; r_req = 0; w_done = 0; r_done = 0; clr0 = 0;
        b_w_req = 0; b_r_req = 0; b_w_done = 0; b_r_done = 0; clr1 = 0;

        // Reset state
        #3;
        check("rst_wg0", {31'd0, wg0}, 0);
        check("rst_rg0", {31'd0, rg0}, 0);
        check("rst_err0", {31'd0, err0}, 0);
        check("rst_cons0", 32'(dut0.cons_cnt_q), 0);
        check("rst_wg1", {31'd0, wg1}, 0);
        check("rst_rg1", {31'd0, rg1}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_wg0", {31'd0, wg0}, 0);

        // Both request from IDLE: write wins, then regrant after wdone
        w_req = 1; r_req = 1;
        tick();
        check("t1_wg", {31'd0, wg0}, 1);
        check("t1_rg", {31'd0, rg0}, 0);
        w_done = 1;
        tick();
        w_done = 0;
        check("t1_regrant_wg", {31'd0, wg0}, 1);
        check("t1_regrant_rg", {31'd0, rg0}, 0);
        check("t1_cons", 32'(dut0.cons_cnt_q), 2);

        // Continuous contention: W,W,W,W,R,W,W,W,W,R
        for (int i = 2; i < 10; i++) begin
            if (exp_r[i-1]) r_done = 1; else w_done = 1;
            tick();
            r_done = 0; w_done = 0;
            check($sformatf("t2_rg_%0d", i), {31'd0, rg0}, {31'd0, exp_r[i]});
            check($sformatf("t2_wg_%0d", i), {31'd0, wg0}, {31'd0, !exp_r[i]});
            check($sformatf("t2_excl_%0d", i), {31'd0, wg0 & rg0}, 0);
        end
        w_req = 0; r_req = 0; r_done = 1;
        tick();
        r_done = 0;
        check("t2_idle_wg", {31'd0, wg0}, 0);
        check("t2_idle_rg", {31'd0, rg0}, 0);

        // Request drop does not release the grant
        w_req = 1;
        tick();
        check("t3_wg_entry", {31'd0, wg0}, 1);
        tick();
        tick();
        w_req = 0;
        tick();
        check("t3_hold_a", {31'd0, wg0}, 1);
        tick();
        check("t3_hold_b", {31'd0, wg0}, 1);
        w_done = 1;
        tick();
        w_done = 0;
        check("t3_release_wg", {31'd0, wg0}, 0);
        check("t3_release_rg", {31'd0, rg0}, 0);
        check("t3_err", {31'd0, err0}, 0);

        // Watchdog expiry on a stuck read grant
        r_req = 1;
        tick();
        r_req = 0;
        check("t4_rg_c0", {31'd0, rg0}, 1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("t4_rg_c%0d", i), {31'd0, rg0}, 1);
            check($sformatf("t4_err_c%0d", i), {31'd0, err0}, 0);
        end
        tick();
        check("t4_rg_fall", {31'd0, rg0}, 0);
        check("t4_err_set", {31'd0, err0}, 1);
        tick();
        check("t4_err_sticky", {31'd0, err0}, 1);
        clr0 = 1;
        tick();
        clr0 = 0;
        check("t4_err_clr", {31'd0, err0}, 0);

        // Done coincident with expiry; foreign done ignored
        r_req = 1;
        tick();
        r_req = 0;
        tick();
        tick();
        w_done = 1;
        tick();
        w_done = 0;
        check("t5_foreign_done_rg", {31'd0, rg0}, 1);
        check("t5_foreign_done_wg", {31'd0, wg0}, 0);
        tick();
        tick();
        tick();
        tick();
        check("t5_last_cycle_rg", {31'd0, rg0}, 1);
        r_done = 1;
        tick();
        r_done = 0;
        check("t5_done_rg", {31'd0, rg0}, 0);
        check("t5_done_err", {31'd0, err0}, 0);
        tick();
        check("t5_done_err_late", {31'd0, err0}, 0);

        // Asynchronous reset mid-grant
        w_req = 1;
        tick();
        w_req = 0;
        check("t6_wg_pre", {31'd0, wg0}, 1);
        #2;
        rst_n = 1'b0;
        r_req = 1;
        #1;
        check("t6_async_wg", {31'd0, wg0}, 0);
        check("t6_async_rg", {31'd0, rg0}, 0);
        tick();
        check("t6_edge1_rg", {31'd0, rg0}, 0);
        #2;
        rst_n = 1'b1;
        tick();
        check("t6_edge2_rg", {31'd0, rg0}, 1);
        check("t6_edge2_wg", {31'd0, wg0}, 0);
        r_req = 0; r_done = 1;
        tick();
        r_done = 0;

        // Read priority, strict, no watchdog
        b_w_req = 1; b_r_req = 1;
        tick();
        check("b_rg_entry", {31'd0, rg1}, 1);
        check("b_wg_entry", {31'd0, wg1}, 0);
        for (int i = 0; i < 6; i++) begin
            b_r_done = 1;
            tick();
            b_r_done = 0;
            check($sformatf("b_strict_rg_%0d", i), {31'd0, rg1}, 1);
        end
        repeat (20) tick();
        check("b_long_hold_rg", {31'd0, rg1}, 1);
        check("b_no_err", {31'd0, err1}, 0);
        b_r_req = 0; b_r_done = 1;
        tick();
        b_r_done = 0;
        check("b_handoff_wg", {31'd0, wg1}, 1);
        check("b_handoff_rg", {31'd0, rg1}, 0);
        b_w_req = 0; b_w_done = 1;
        tick();
        b_w_done = 0;
        check("b_idle_wg", {31'd0, wg1}, 0);
        check("b_idle_rg", {31'd0, rg1}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/asi_arb.md
Name: asi_arb

Overview:
- Arbiter sharing the single user-side memory port between the AXI slave write path (asi_w) and the AXI slave read path (asi_r).
- Grants one path at a time and holds the grant for a whole burst.
- Fixed priority is selected by ASI_ARB; a consecutive-grant limit bounds starvation of the low-priority side.
- A per-grant watchdog force-releases a grant whose burst never completes.
- Runs entirely in the usr_clk domain.

Parameters:
ASI_ARB, 0, 1 = read has priority; 0 = write has priority
MAX_CONSEC, 4, max consecutive priority-side grants while the other side requests; 0 = strict priority (no limit)
TIMEOUT, 1024, max cycles a grant may be held without a done pulse; 0 = watchdog disabled
CNTW, $clog2(TIMEOUT+1) (minimum 1), watchdog counter width (derived)
CONW, $clog2(MAX_CONSEC+1) (minimum 1), consecutive counter width (derived)

Ports:
clk  in  1  clock (usr_clk)
rst_n  in  1  asynchronous active-low reset
usr_wrequest  in  1  write path has a pending burst
usr_rrequest  in  1  read path has a pending burst
usr_wdone  in  1  single-cycle pulse: last write beat accepted (usr_we & usr_wlast)
usr_rdone  in  1  single-cycle pulse: last read beat issued
usr_wgrant  out  1  write path owns the port
usr_rgrant  out  1  read path owns the port
arb_err  out  1  sticky: watchdog expired at least once
err_clr  in  1  clears arb_err

Behaviour:
- Reset values: state IDLE, usr_wgrant=0, usr_rgrant=0, arb_err=0, all counters 0. Reset asserted mid-grant drops both grants asynchronously.
- States:
  - IDLE: no owner.
  - WGNT: usr_wgrant=1.
  - RGNT: usr_rgrant=1.
- Grants are registered decodes of state. They are never both 1 in any cycle.
- Arbitration point: any cycle in IDLE, and any cycle in WGNT/RGNT with the matching done pulse or watchdog expiry.
  - Arbitration uses the requests sampled in that cycle.
  - The winner's grant is asserted on the next cycle (1-cycle latency).
  - With no requests, the next state is IDLE.
- Winner selection:
  - Only one side requesting: that side wins.
  - Both sides requesting: the priority side wins, unless MAX_CONSEC != 0 and cons_cnt == MAX_CONSEC, in which case the other side wins.
- Handoff: on done with a request pending, the block goes directly WGNT->RGNT, RGNT->WGNT, or back to the same grant. There is no IDLE bubble.
- Grant hold: once granted, the grant is held until the done pulse or watchdog expiry. Request deassertion during a grant does NOT release it.
- A done pulse for the non-owning side, or arriving in IDLE, is ignored.
- cons_cnt:
  - Increments (saturating at MAX_CONSEC) when the priority side wins while the other side is also requesting.
  - Clears to 0 when the non-priority side is granted.
  - Unchanged otherwise.
- Watchdog (TIMEOUT != 0):
  - wd_cnt clears on every grant entry, including a same-side regrant, and increments each cycle in WGNT/RGNT.
  - Expiry occurs when wd_cnt == TIMEOUT-1 and no done pulse is present. It behaves as a done (arbitration point) and sets arb_err the next cycle.
  - Done and expiry in the same cycle: done wins and arb_err is not set.
- arb_err is cleared by err_clr on the next cycle. err_clr and a new expiry in the same cycle: set wins.
- TIMEOUT=0: wd_cnt is held at 0 and arb_err stays 0.

Test Plan:
- ASI_ARB=0: wrequest=1 and rrequest=1 from IDLE -> usr_wgrant=1 one cycle later; usr_wdone pulse with both still requesting -> next cycle usr_rgrant=0, usr_wgrant=1, cons_cnt=2.
- MAX_CONSEC=4, both sides continuously requesting, ASI_ARB=0 -> grant sequence W,W,W,W,R,W,W,W,W,R. The two grants are never high together.
- usr_wrequest drops two cycles into WGNT with no done -> usr_wgrant stays 1 until the usr_wdone pulse, then IDLE (both grants 0) if there are no requests.
- TIMEOUT=8, usr_rgrant held with no usr_rdone -> usr_rgrant falls after 8 cycles and arb_err=1 next cycle; err_clr pulse -> arb_err=0 next cycle.
- usr_rdone and expiry in the same cycle -> arb_err stays 0. usr_wdone pulsed during RGNT -> ignored, usr_rgrant stays 1.
- rst_n asserted mid-WGNT -> usr_wgrant=0 immediately. After release with only rrequest=1 -> usr_rgrant=1 on the 2nd clk edge.
